// File: rtl/button_led_pkg.sv
// Shared definitions for the button-driven LED sequencer: mode codes,
// mode width and the helper that steps through the display modes.
package button_led_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF    = 3'd0,
      MODE_FOLLOW = 3'd1,
      MODE_CHASE  = 3'd2,
      MODE_BLINK  = 3'd3,
      MODE_BAR    = 3'd4
   } modeT;

   // Advance to the next display mode. Codes 5-7 can never be produced by
   // the sequencer; if one ever shows up it behaves as OFF, so the next
   // short press lands on FOLLOW just as it would from OFF.
   function automatic modeT next_mode(input logic [MODE_W-1:0] cur);
      case (cur)
         MODE_OFF:    return MODE_FOLLOW;
         MODE_FOLLOW: return MODE_CHASE;
         MODE_CHASE:  return MODE_BLINK;
         MODE_BLINK:  return MODE_BAR;
         MODE_BAR:    return MODE_OFF;
         default:     return MODE_FOLLOW;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Brings the raw, bouncy board button into the clock domain and only accepts
// a new level once it has held steady long enough. Also produces one-cycle
// pulses on the cycle the accepted level rises or falls.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic CLK,
   input  logic RST,
   input  logic BUTTON,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic syncMeta;
   logic syncOut;
   logic [CNT_W-1:0] count;

   // Two-flop synchroniser. The button is asynchronous to the clock, so the
   // first flop may go metastable; only the second flop's output is used.
   always_ff @(posedge CLK) begin
      if (RST) begin
         syncMeta <= 1'b0;
         syncOut  <= 1'b0;
      end else begin
         syncMeta <= BUTTON;
         syncOut  <= syncOut == syncMeta ? syncMeta : syncMeta;
      end
   end

   // Debounce counter. Any cycle where the synchronised input agrees with the
   // accepted level restarts the count, so a level is only accepted after
   // DEBOUNCE_CYCLES consecutive disagreeing cycles. The edge pulses are
   // registered together with the new level so they line up with it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         count  <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (syncOut == stable) begin
            count <= '0;
         end else if (count == CNT_LAST) begin
            count  <= '0;
            stable <= syncOut;
            rise   <= syncOut;
            fall   <= ~syncOut;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_led_sequencer.sv
// Top of the LED sequencer: turns debounced button activity into short and
// long presses, steps through the display modes and drives the LED bank
// with the pattern for the current mode, paced by a tick prescaler.
module button_led_sequencer
   import button_led_pkg::*;
#(
   parameter int NUM_LEDS         = 5,
   parameter int DEBOUNCE_CYCLES  = 250000,
   parameter int TICK_CYCLES      = 5000000,
   parameter int LONG_PRESS_TICKS = 20
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                BUTTON,
   output logic [NUM_LEDS-1:0] LED,
   output logic [MODE_W-1:0]   MODE,
   output logic                PRESS
);

   localparam int PRESC_W = $clog2(TICK_CYCLES);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
   localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(LONG_PRESS_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_FIRE  = HOLD_W'(LONG_PRESS_TICKS - 1);

   logic                stable;
   logic                rise;
   logic                fall;
   logic [PRESC_W-1:0]  prescaler;
   logic                tick;
   logic [HOLD_W-1:0]   holdTicks;
   logic                longFired;
   logic                longFire;
   logic                shortPress;
   modeT                modeState;
   modeT                modeNext;
   logic                modeChange;
   logic [NUM_LEDS-1:0] ledNext;
   logic                pressNext;

   // Starting LED value for a freshly entered mode. FOLLOW mirrors the
   // accepted button level, which is always released on entry.
   function automatic logic [NUM_LEDS-1:0] initPattern(input modeT m, input logic s);
      case (m)
         MODE_FOLLOW: return {s, {(NUM_LEDS-1){1'b0}}};
         MODE_CHASE:  return NUM_LEDS'(1);
         MODE_BLINK:  return '1;
         default:     return '0;
      endcase
   endfunction

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) uDebounce (
      .CLK    (CLK),
      .RST    (RST),
      .BUTTON (BUTTON),
      .stable (stable),
      .rise   (rise),
      .fall   (fall)
   );

   assign tick       = (prescaler == PRESC_LAST);
   assign longFire   = stable && !rise && tick && !longFired && (holdTicks == HOLD_FIRE);
   assign shortPress = fall && !longFired;
   assign modeChange = (modeNext != modeState);
   assign MODE       = modeState;

   // Tick prescaler. Free-running, but restarted whenever the mode actually
   // changes so every pattern gets a full tick period before its first step.
   always_ff @(posedge CLK) begin
      if (RST) begin
         prescaler <= '0;
      end else if (modeChange || tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Hold tracking. Counts ticks while the button is held, restarting on each
   // accepted press and saturating at the long-press limit. longFired makes
   // sure a single hold only ever triggers one long press, and it also tells
   // the following release to stay silent instead of acting as a short press.
   always_ff @(posedge CLK) begin
      if (RST) begin
         holdTicks <= '0;
         longFired <= 1'b0;
      end else begin
         if (rise) begin
            holdTicks <= '0;
         end else if (stable && tick && (holdTicks != HOLD_LIMIT)) begin
            holdTicks <= holdTicks + 1'b1;
         end
         if (longFire) begin
            longFired <= 1'b1;
         end else if (fall) begin
            longFired <= 1'b0;
         end
      end
   end

   // Mode state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         modeState <= MODE_OFF;
      end else begin
         modeState <= modeNext;
      end
   end

   // Next mode: a long press always forces OFF; otherwise a short press steps
   // to the following mode.
   always_comb begin
      modeNext = modeState;
      if (longFire) begin
         modeNext = MODE_OFF;
      end else if (shortPress) begin
         modeNext = next_mode(modeState);
      end
   end

   // Next LED and PRESS values. A mode change (short or long press) takes
   // priority over a tick landing on the same cycle: the new pattern starts
   // from its initial value and that tick is simply lost.
   always_comb begin
      pressNext = shortPress;
      ledNext   = LED;
      if (longFire || shortPress) begin
         ledNext = initPattern(modeNext, stable);
      end else begin
         case (modeState)
            MODE_OFF: begin
               ledNext = '0;
            end
            MODE_FOLLOW: begin
               ledNext = {stable, {(NUM_LEDS-1){1'b0}}};
            end
            MODE_CHASE: begin
               if (tick) ledNext = {LED[NUM_LEDS-2:0], LED[NUM_LEDS-1]};
            end
            MODE_BLINK: begin
               if (tick) ledNext = ~LED;
            end
            MODE_BAR: begin
               if (tick) ledNext = (&LED) ? '0 : {LED[NUM_LEDS-2:0], 1'b1};
            end
            default: begin
               ledNext = '0;
            end
         endcase
      end
   end

   // Output registers, so LED and PRESS never have a combinational path
   // back to the button pin.
   always_ff @(posedge CLK) begin
      if (RST) begin
         LED   <= '0;
         PRESS <= 1'b0;
      end else begin
         LED   <= ledNext;
         PRESS <= pressNext;
      end
   end

endmodule

// File: tb/tb_button_led_sequencer.sv
// Randomised self-checking bench for button_led_sequencer. A behavioural
// model built from the button/pattern rules predicts LED, MODE, PRESS and
// the debounced level every cycle.
module tb_button_led_sequencer;

   localparam int NUM_LEDS = 5;
   localparam int DEB      = 4;
   localparam int TICK     = 8;
   localparam int LONGP    = 3;
   localparam int ALL_ONES = (1 << NUM_LEDS) - 1;

   logic                CLK = 1'b0;
   logic                RST;
   logic                BUTTON;
   logic [NUM_LEDS-1:0] LED;
   logic [2:0]          MODE;
   logic                PRESS;

   int compared   = 0;
   int mismatched = 0;

   int edgeNo     = 0;
   int clearEdge  = 0;
   int modelMode  = 0;
   int modelLed   = 0;
   int modelPress = 0;
   int modelTicks = 0;
   int modelHold  = 0;
   bit modelStable     = 1'b0;
   bit modelFallPend   = 1'b0;
   bit modelRisePend   = 1'b0;
   bit modelLongFired  = 1'b0;
   bit samp[$];

   button_led_sequencer #(
      .NUM_LEDS         (NUM_LEDS),
      .DEBOUNCE_CYCLES  (DEB),
      .TICK_CYCLES      (TICK),
      .LONG_PRESS_TICKS (LONGP)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .BUTTON (BUTTON),
      .LED    (LED),
      .MODE   (MODE),
      .PRESS  (PRESS)
   );

   always #5 CLK = ~CLK;

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, observed, expected, edgeNo);
      end
   endtask

   // Drive the button level for a number of cycles.
   task automatic applyStimulus(input logic btn, input int cycles);
      BUTTON = btn;
      repeat (cycles) @(negedge CLK);
   endtask

   task automatic pressShort();
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 12);
   endtask

   task automatic gotoMode(input int m);
      for (int i = 0; i < 6; i++) begin
         if (modelMode == m) break;
         pressShort();
      end
   endtask

   // Release so that the resulting mode change lands on a tick cycle.
   task automatic alignedPress();
      applyStimulus(1'b1, 6);
      for (int i = 0; i < TICK; i++) begin
         if (((edgeNo + DEB + 3 - clearEdge) % TICK) == 0) break;
         applyStimulus(1'b1, 1);
      end
      applyStimulus(1'b0, 20);
   endtask

   // Expected LED for a mode after n ticks spent in it.
   function automatic int ledFor(input int mode, input int n, input bit s);
      case (mode)
         1:       return s ? (1 << (NUM_LEDS - 1)) : 0;
         2:       return 1 << (n % NUM_LEDS);
         3:       return ((n % 2) == 0) ? ALL_ONES : 0;
         4:       return (1 << (n % (NUM_LEDS + 1))) - 1;
         default: return 0;
      endcase
   endfunction

   // Reference model, advanced once per rising edge from the pre-edge state,
   // then compared against the DUT just after the edge.
   always @(posedge CLK) begin
      bit tickNow;
      bit fire;
      bit shortP;
      bit flip;
      bit prevStable;
      int newMode;
      edgeNo++;
      if (RST) begin
         modelStable    = 1'b0;
         modelFallPend  = 1'b0;
         modelRisePend  = 1'b0;
         modelLongFired = 1'b0;
         modelMode      = 0;
         modelLed       = 0;
         modelPress     = 0;
         modelTicks     = 0;
         modelHold      = 0;
         clearEdge      = edgeNo;
         samp.delete();
      end else begin
         tickNow = (edgeNo > clearEdge) && (((edgeNo - clearEdge) % TICK) == 0);
         fire    = modelStable && !modelRisePend && tickNow && !modelLongFired && (modelHold == LONGP - 1);
         shortP  = modelFallPend && !modelLongFired;
         newMode = modelMode;
         if (fire) newMode = 0;
         else if (shortP) newMode = (modelMode + 1) % 5;
         if (fire || shortP) begin
            modelTicks = 0;
            modelLed   = ledFor(newMode, 0, modelStable);
         end else begin
            if (tickNow) modelTicks++;
            modelLed = ledFor(modelMode, modelTicks, modelStable);
         end
         modelPress = shortP ? 1 : 0;
         if (modelRisePend) modelHold = 0;
         else if (modelStable && tickNow && modelHold < LONGP) modelHold++;
         if (fire) modelLongFired = 1'b1;
         else if (modelFallPend) modelLongFired = 1'b0;
         if (newMode != modelMode) clearEdge = edgeNo;
         modelMode = newMode;
         flip = 1'b1;
         for (int i = 1; i <= DEB; i++) begin
            bit s;
            s = (i < samp.size()) ? samp[i] : 1'b0;
            if (s == modelStable) flip = 1'b0;
         end
         prevStable = modelStable;
         if (flip) modelStable = !modelStable;
         modelFallPend = prevStable && !modelStable;
         modelRisePend = !prevStable && modelStable;
         samp.push_front(BUTTON);
         while (samp.size() > DEB + 1) void'(samp.pop_back());
      end
      #1;
      checkOutput("led",    32'(LED),                 32'(modelLed));
      checkOutput("mode",   32'(MODE),                32'(modelMode));
      checkOutput("press",  32'(PRESS),               32'(modelPress));
      checkOutput("stable", 32'(dut.uDebounce.stable), 32'(modelStable));
   end

   initial begin
      RST    = 1'b1;
      BUTTON = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      $display("[TB] reset released with button held");
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 12);

      $display("[TB] bounce bursts");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3);
         applyStimulus(1'b0, 3);
      end

      $display("[TB] short presses");
      for (int i = 0; i < 5; i++) pressShort();

      $display("[TB] pattern runs");
      gotoMode(2);
      applyStimulus(1'b0, 60);
      gotoMode(3);
      applyStimulus(1'b0, 20);
      gotoMode(4);
      applyStimulus(1'b0, 60);

      $display("[TB] long press");
      gotoMode(2);
      applyStimulus(1'b1, 40);
      applyStimulus(1'b0, 15);
      pressShort();

      $display("[TB] press coinciding with tick");
      gotoMode(2);
      alignedPress();
      gotoMode(3);
      alignedPress();
      gotoMode(1);
      alignedPress();

      $display("[TB] random stimulus");
      for (int i = 0; i < 80; i++) begin
         int r;
         r = int'($urandom_range(0, 11));
         if (r == 0) begin
            RST = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            RST = 1'b0;
         end else if (r < 3) begin
            for (int j = 0; j < 3; j++) begin
               applyStimulus(1'b1, int'($urandom_range(1, 3)));
               applyStimulus(1'b0, int'($urandom_range(1, 3)));
            end
         end else begin
            applyStimulus(1'b1, int'($urandom_range(1, 45)));
            applyStimulus(1'b0, int'($urandom_range(1, 25)));
         end
      end
      applyStimulus(1'b0, 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
